aether_pifo_leaf: RTL and testbench

- Terminal child store of the Aether PIFO tree; the receiving end of a node's child command port (valid/op/data/mask).
- Captures push commands (entries a full parent evicts) and serves pop/refill requests, returning the best-priority entry to the parent.
- Holds up to DEPTH entries, kept sorted in a register array.
- One instance per child lane; each instance is selected by its bit in the parent's mask.

---
 rtl/aether_pifo_pkg.sv | 25 ++
 rtl/aether_pifo_insert_enc.sv | 27 ++
 rtl/aether_pifo_leaf.sv | 132 +++++++++++++
 tb/tb_aether_pifo_leaf.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/aether_pifo_pkg.sv
// Shared types for the Aether PIFO tree (node and leaf).
//   entry_t    : {meta, prio} packed at the tree's default widths
//   OP_PUSH/POP: child command opcodes
//   sentinel() : "no entry" value, worst possible priority with zero meta
package aether_pifo_pkg;

    localparam int DEF_PTW = 16;
    localparam int DEF_MTW = 32;

    typedef struct packed {
        logic [DEF_MTW-1:0] meta;
        logic [DEF_PTW-1:0] prio;
    } entry_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    function automatic entry_t sentinel();
        entry_t s;
        s.meta = '0;
        s.prio = '1;
        return s;
    endfunction

endpackage

// File: rtl/aether_pifo_insert_enc.sv
// Insertion-index encoder for the sorted leaf store.
//   gt  : per slot, stored prio strictly greater than the incoming prio
//   occ : per slot, slot holds a live entry (contiguous from slot 0)
//   k   : first occupied slot with gt set, else the occupancy (0..DEPTH)
// Using strict-greater keeps equal priorities in arrival order.
module aether_pifo_insert_enc #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]              gt,
    input  logic [DEPTH-1:0]              occ,
    output logic [$clog2(DEPTH+1)-1:0]    k
);
    localparam int KW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] hit;
    assign hit = gt & occ;

    always_comb begin
        k = '0;
        for (int i = 0; i < DEPTH; i++)
            k = k + KW'(occ[i]);
        // Scan high to low so the lowest hitting slot wins.
        for (int i = DEPTH - 1; i >= 0; i--)
            if (hit[i]) k = KW'(i);
    end

endmodule

// File: rtl/aether_pifo_leaf.sv
// Terminal child store of the Aether PIFO tree.
// Receives the parent's child command port and keeps up to DEPTH entries
// sorted by priority (smaller prio = better) in a register array.
//   i_clk, i_arst_n          : clock, async active-low reset
//   i_valid/i_op/i_data/i_mask: command from parent; ours iff i_mask[LANE_ID]
//   o_pop_valid/hit/data     : registered pop response, one cycle after accept
//   o_head_data              : current best entry (sentinel when empty)
//   o_count/o_full/o_empty   : occupancy
//   o_drop_pulse/o_drop_cnt  : discarded-entry strobe and saturating count
module aether_pifo_leaf
    import aether_pifo_pkg::*;
#(
    parameter int PTW     = 16,
    parameter int MTW     = 32,
    parameter int DEPTH   = 8,
    parameter int LANES   = 4,
    parameter int LANE_ID = 3,
    parameter int DCW     = 16
) (
    input  logic                        i_clk,
    input  logic                        i_arst_n,
    input  logic                        i_valid,
    input  logic                        i_op,
    input  logic [MTW+PTW-1:0]          i_data,
    input  logic [LANES-1:0]            i_mask,
    output logic                        o_pop_valid,
    output logic                        o_pop_hit,
    output logic [MTW+PTW-1:0]          o_pop_data,
    output logic [MTW+PTW-1:0]          o_head_data,
    output logic [$clog2(DEPTH+1)-1:0]  o_count,
    output logic                        o_full,
    output logic                        o_empty,
    output logic                        o_drop_pulse,
    output logic [DCW-1:0]              o_drop_cnt
);
    localparam int EW = MTW + PTW;
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [MTW-1:0] meta;
        logic [PTW-1:0] prio;
    } ent_t;

    localparam ent_t SENT = {{MTW{1'b0}}, {PTW{1'b1}}};

    ent_t            slots  [DEPTH];
    ent_t            ins_v  [DEPTH];
    ent_t            pop_v  [DEPTH];
    ent_t            dn     [DEPTH];
    ent_t            new_e;
    logic [CW-1:0]   count;
    logic [CW-1:0]   k;
    logic [DEPTH-1:0] gt, occ;
    logic            acc, full, empty, discard;

    assign new_e   = ent_t'(i_data);
    assign acc     = i_valid & i_mask[LANE_ID];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Full and no slot worse than the newcomer: the newcomer itself is lost.
    assign discard = full && (k == CW'(DEPTH));

    // Per-slot compare plus the two shifted views of the array.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign gt[g]  = slots[g].prio > new_e.prio;
        assign occ[g] = CW'(g) < count;

        if (g == 0) begin : g_first
            assign dn[g] = new_e;
        end else begin : g_rest
            assign dn[g] = slots[g-1];
        end

        if (g == DEPTH - 1) begin : g_last
            assign pop_v[g] = SENT;
        end else begin : g_up
            assign pop_v[g] = slots[g+1];
        end

        // Below k keep, at k insert, above k shift down (last slot falls off).
        assign ins_v[g] = (CW'(g) < k)  ? slots[g] :
                          (CW'(g) == k) ? new_e    : dn[g];
    end

    aether_pifo_insert_enc #(.DEPTH(DEPTH)) u_enc (
        .gt  (gt),
        .occ (occ),
        .k   (k)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= SENT;
            count        <= '0;
            o_pop_valid  <= 1'b0;
            o_pop_hit    <= 1'b0;
            o_pop_data   <= SENT;
            o_drop_pulse <= 1'b0;
            o_drop_cnt   <= '0;
        end else begin
            o_pop_valid  <= 1'b0;
            o_drop_pulse <= 1'b0;
            if (acc) begin
                if (i_op == OP_POP) begin
                    o_pop_valid <= 1'b1;
                    o_pop_hit   <= !empty;
                    o_pop_data  <= empty ? SENT : slots[0];
                    if (!empty) begin
                        for (int i = 0; i < DEPTH; i++) slots[i] <= pop_v[i];
                        count <= count - CW'(1);
                    end
                end else begin
                    if (!discard)
                        for (int i = 0; i < DEPTH; i++) slots[i] <= ins_v[i];
                    if (!full)
                        count <= count + CW'(1);
                    else begin
                        o_drop_pulse <= 1'b1;
                        if (o_drop_cnt != {DCW{1'b1}})
                            o_drop_cnt <= o_drop_cnt + DCW'(1);
                    end
                end
            end
        end
    end

    assign o_head_data = empty ? SENT : slots[0];
    assign o_count     = count;
    assign o_full      = full;
    assign o_empty     = empty;

endmodule

// File: tb/tb_aether_pifo_leaf.sv
module tb_aether_pifo_leaf;
    localparam logic [47:0] SENT = 48'h0000_0000_FFFF;
    localparam int DEPTH = 8;
    localparam int DMAX  = 3;   // DCW = 2

    logic        i_clk = 1'b0;
    logic        i_arst_n = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_op = 1'b0;
    logic [47:0] i_data = '0;
    logic [3:0]  i_mask = '0;
    logic        o_pop_valid, o_pop_hit, o_full, o_empty, o_drop_pulse;
    logic [47:0] o_pop_data, o_head_data;
    logic [3:0]  o_count;
    logic [1:0]  o_drop_cnt;

    aether_pifo_leaf #(.DCW(2)) dut (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .i_valid(i_valid), .i_op(i_op),
        .i_data(i_data), .i_mask(i_mask), .o_pop_valid(o_pop_valid),
        .o_pop_hit(o_pop_hit), .o_pop_data(o_pop_data), .o_head_data(o_head_data),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
        .o_drop_pulse(o_drop_pulse), .o_drop_cnt(o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] E(input logic [31:0] m, input logic [15:0] p);
        return {m, p};
    endfunction

    // Behavioural model: a sorted queue plus the expected response registers.
    logic [47:0] mq[$];
    logic        m_pv = 0, m_hit = 0, m_drop = 0;
    logic [47:0] m_pdata = SENT;
    int          m_dcnt = 0;

    initial forever begin
        @(posedge i_clk or negedge i_arst_n);
        if (!i_arst_n) begin
            mq.delete();
            m_pv = 0; m_hit = 0; m_drop = 0; m_pdata = SENT; m_dcnt = 0;
        end else begin
            m_pv = 0; m_drop = 0;
            if (i_valid && i_mask[3]) begin
                if (i_op) begin
                    m_pv = 1;
                    if (mq.size() == 0) begin
                        m_hit = 0; m_pdata = SENT;
                    end else begin
                        m_hit = 1; m_pdata = mq.pop_front();
                    end
                end else begin
                    int k;
                    k = mq.size();
                    for (int i = 0; i < mq.size(); i++)
                        if (mq[i][15:0] > i_data[15:0]) begin k = i; break; end
                    if (mq.size() == DEPTH) begin
                        m_drop = 1;
                        if (m_dcnt < DMAX) m_dcnt++;
                    end
                    if (!(mq.size() == DEPTH && k == DEPTH)) begin
                        mq.insert(k, i_data);
                        if (mq.size() > DEPTH) void'(mq.pop_back());
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge i_clk);
        if (chk_en) begin
            chk("count", 64'(o_count), 64'(mq.size()));
            chk("head", 64'(o_head_data), 64'(mq.size() ? mq[0] : SENT));
            chk("full", 64'(o_full), 64'(mq.size() == DEPTH));
            chk("empty", 64'(o_empty), 64'(mq.size() == 0));
            chk("pop_valid", 64'(o_pop_valid), 64'(m_pv));
            chk("pop_data", 64'(o_pop_data), 64'(m_pdata));
            if (m_pv) chk("pop_hit", 64'(o_pop_hit), 64'(m_hit));
            chk("drop_pulse", 64'(o_drop_pulse), 64'(m_drop));
            chk("drop_cnt", 64'(o_drop_cnt), 64'(m_dcnt));
        end
    end

    // Starts and ends on a negedge; the command is taken at the posedge between.
    task automatic cmd(input logic v, input logic op, input logic [47:0] d, input logic [3:0] m);
        #1;
        i_valid = v; i_op = op; i_data = d; i_mask = m;
        @(negedge i_clk);
    endtask

    task automatic push(input logic [47:0] d); cmd(1, 0, d, 4'b1000); endtask
    task automatic pop();                      cmd(1, 1, '0, 4'b1000); endtask
    task automatic idle();                     cmd(0, 0, '0, 4'b0000); endtask

    initial begin
        #2 i_arst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_arst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_empty", 64'(o_empty), 64'd1);
        chk("rst_head", 64'(o_head_data), 64'(SENT));
        chk("rst_pop_data", 64'(o_pop_data), 64'(SENT));
        chk("rst_pop_valid", 64'(o_pop_valid), 64'd0);
        chk("rst_drop_cnt", 64'(o_drop_cnt), 64'd0);

        // Pop on empty leaf.
        pop();
        chk("empty_pv", 64'(o_pop_valid), 64'd1);
        chk("empty_hit", 64'(o_pop_hit), 64'd0);
        chk("empty_data", 64'(o_pop_data), 64'h0000_0000_FFFF);
        idle();

        // Sorted order.
        push(E(32'hA, 30)); push(E(32'hB, 10)); push(E(32'hC, 20));
        pop(); chk("sort0", 64'(o_pop_data), 64'h0000_000B_000A);
        chk("sort0_hit", 64'(o_pop_hit), 64'd1);
        pop(); chk("sort1", 64'(o_pop_data), 64'h0000_000C_0014);
        pop(); chk("sort2", 64'(o_pop_data), 64'h0000_000A_001E);
        idle(); chk("sort_empty", 64'(o_empty), 64'd1);
        chk("hold_data", 64'(o_pop_data), 64'h0000_000A_001E);

        // Equal priorities stay FIFO.
        push(E(32'h1, 5)); push(E(32'h2, 5));
        pop(); chk("tie0", 64'(o_pop_data), 64'h0000_0001_0005);
        pop(); chk("tie1", 64'(o_pop_data), 64'h0000_0002_0005);

        // Fill, then evict the worst, then discard a too-poor newcomer.
        for (int i = 1; i <= 8; i++) push(E(32'(i), 16'(10 * i)));
        chk("fill_full", 64'(o_full), 64'd1);
        push(E(32'h15, 15));
        chk("evict_pulse", 64'(o_drop_pulse), 64'd1);
        chk("evict_cnt", 64'(o_drop_cnt), 64'd1);
        chk("evict_head", 64'(o_head_data), 64'h0000_0001_000A);
        chk("evict_count", 64'(o_count), 64'd8);
        push(E(32'h90, 90));
        chk("discard_pulse", 64'(o_drop_pulse), 64'd1);
        chk("discard_cnt", 64'(o_drop_cnt), 64'd2);
        idle();
        chk("pulse_clear", 64'(o_drop_pulse), 64'd0);

        // Not our lane.
        cmd(1, 1, '0, 4'b0001);
        chk("unsel_pv", 64'(o_pop_valid), 64'd0);
        chk("unsel_count", 64'(o_count), 64'd8);
        cmd(1, 0, E(32'h5, 1), 4'b0111);
        chk("unsel_head", 64'(o_head_data), 64'h0000_0001_000A);

        // Push then pop on the very next cycle.
        push(E(32'h77, 1));
        pop(); chk("b2b", 64'(o_pop_data), 64'h0000_0077_0001);
        chk("b2b_count", 64'(o_count), 64'd7);
        pop(); pop();
        chk("pre_rst_count", 64'(o_count), 64'd5);

        // Reset while a pop response is in flight.
        #1 i_valid = 1; i_op = 1; i_mask = 4'b1000;
        @(posedge i_clk);
        #1 i_arst_n = 1'b0; i_valid = 0;
        #1;
        chk("mid_rst_pv", 64'(o_pop_valid), 64'd0);
        chk("mid_rst_count", 64'(o_count), 64'd0);
        chk("mid_rst_head", 64'(o_head_data), 64'(SENT));
        @(posedge i_clk);
        #1 i_arst_n = 1'b1;
        @(negedge i_clk);

        // Drop counter saturation (2-bit counter).
        for (int i = 1; i <= 8; i++) push(E(32'(i), 16'(10 * i)));
        for (int i = 0; i < 5; i++) push(E(32'h99, 100));
        chk("sat_cnt", 64'(o_drop_cnt), 64'd3);
        chk("sat_head", 64'(o_head_data), 64'h0000_0001_000A);
        idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
